util_sym_pack: RTL and testbench
================================

// Module: util_sym_pack
// PURPOSE
//  - Sequential symbol packer: collects B_NUM-bit symbols one per beat and emits one S_NUM*B_NUM-bit word.
//  - Receive-side counterpart of the word-level symbol reorder path.
//  - Sits between a narrow symbol stream and a wide word datapath.
//  - Supports short final words (keep mask) on s_last.
// PARAMETERS
//  - S_NUM  4  symbols per output word (>=1)
//  - B_NUM  8  bits per symbol (>=1)
// PORTS
//  - clk      in   1            single clock, all logic rising-edge
//  - rst      in   1            synchronous, active-high reset
//  - s_valid  in   1            input symbol valid
//  - s_ready  out  1            input symbol accepted when s_valid & s_ready
//  - s_data   in   B_NUM        input symbol
//  - s_last   in   1            last symbol of packet; closes current word
//  - m_valid  out  1            output word valid
//  - m_ready  in   1            output word consumed when m_valid & m_ready
//  - m_data   out  S_NUM*B_NUM  packed word
//  - m_keep   out  S_NUM        1 per filled symbol slot
//  - m_last   out  1            word closed by s_last
// BEHAVIOUR
//  - Reset (sync, active-high, overrides all): m_valid=0, m_data=0, m_keep=0, m_last=0, slot counter=0, accumulator=0.
//  - rst mid-word discards the partial word; no output is produced for it.
//  - s_ready = !m_valid | m_ready: combinational, no dependency on s_valid/s_last.
//  - Accept: the symbol is written to slot cnt (bits cnt*B_NUM +: B_NUM); its keep bit is set; cnt increments.
//  - Word completes on an accepted beat with cnt==S_NUM-1 or s_last=1.
//  - On completion, the output register loads the accumulator (including the current symbol), keep, and m_last=s_last.
//  - On completion, m_valid=1 from the next cycle (latency 1 clk after the closing accept).
//  - On completion, cnt and the accumulator clear to 0 in the same edge.
//  - Unfilled slots of a short word are 0; their keep bits are 0.
//  - s_last at cnt==S_NUM-1 gives a full word with m_last=1.
//  - Output register holds m_data/m_keep/m_last stable while m_valid & !m_ready.
//  - Simultaneous m_ready and a closing accept: old word leaves, new word loads, m_valid stays 1 (no bubble).
//  - Non-closing accepts while m_valid=1 are allowed only via s_ready, i.e. only when m_ready=1.
//  - S_NUM=1: every accepted beat closes a word.
//  - Counter width: clog2(S_NUM), minimum 1 bit. The counter wraps to 0 only on completion, never by overflow.
// CONFIGURATION
//  - Macro UTIL_SYM_PACK_MSB_FIRST_EN.
//  - Undefined (default): first symbol goes to slot 0 (LSB). Output {s3,s2,s1,s0}.
//  - Defined: first symbol goes to slot S_NUM-1-cnt (MSB first); keep bits are mirrored to match.
//  - Defined: a short word is left-aligned, with zeros in the low slots.
//  - Handshake, latency and reset behaviour are identical in both builds.
// STRUCTURE
//  - Shared include util_sym_defs.vh holds:
//    - clog2 function
//    - localparam W = S_NUM*B_NUM
//    - CNT_W = max(1, clog2(S_NUM))
//    - slot-index macro used by both orderings
//  - Sub-module util_sym_pack_acc: slot counter plus accumulator/keep write-decoder. It has a done strobe output.
//  - The top level holds the output register and the handshake.
// TESTING (S_NUM=4, B_NUM=8, default build unless noted)
//  - Full word, m_ready=1: 0x11,0x22,0x33,0x44, no s_last.
//    -> m_data=0x44332211, m_keep=0xF, m_last=0, m_valid 1 clk after 4th accept.
//  - Short word: 0xAA, then 0xBB with s_last=1.
//    -> m_data=0x0000BBAA, m_keep=0x3, m_last=1; next word starts at slot 0.
//  - Backpressure: word ready, m_ready=0 for 5 clks.
//    -> s_ready=0, outputs stable.
//    -> m_ready=1: word leaves, s_ready=1 the same cycle, next word intact.
//  - Reset mid-word: accept 0x01,0x02, assert rst 1 clk, then send 0x10..0x40.
//    -> single word 0x40302010, keep 0xF; no earlier output.
//  - MSB_FIRST_EN defined:
//    -> 0x11..0x44 gives 0x11223344.
//    -> 0xAA, 0xBB+s_last gives 0xAABB0000, keep 0xC.
//  - Random s_valid/m_ready, 1000 symbols with random s_last, checked against a scoreboard model.
//    -> no loss or duplication; zero bubbles when m_ready=1.

Source files
------------

// File: rtl/util_sym_pack_pkg.sv
// Shared definitions for the symbol packer: slot ordering, counter sizing and slot-index helper.
package util_sym_pack_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned s_num);
    return (clog2(s_num) < 1) ? 1 : clog2(s_num);
  endfunction

  // Maps the arrival index of a symbol to its slot in the output word.
  function automatic int unsigned slot_idx(input int unsigned cnt,
                                           input int unsigned s_num,
                                           input order_e      order);
    return (order == ORDER_MSB_FIRST) ? (s_num - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/util_sym_pack_if.sv
// Symbol-in / word-out stream bundle for util_sym_pack.
interface util_sym_pack_if #(
  parameter int unsigned S_NUM = 4,
  parameter int unsigned B_NUM = 8
);
  logic                   s_valid;
  logic                   s_ready;
  logic [B_NUM-1:0]       s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [S_NUM*B_NUM-1:0] m_data;
  logic [S_NUM-1:0]       m_keep;
  logic                   m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/util_sym_pack_acc.sv
// Slot counter and accumulator/keep write-decoder; `word`/`keep` include the current beat.
// Build option: UTIL_SYM_PACK_MSB_FIRST_EN places the first symbol in the top slot.
module util_sym_pack_acc
  import util_sym_pack_pkg::*;
#(
  parameter int unsigned S_NUM = 4,
  parameter int unsigned B_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept,
  input  logic [B_NUM-1:0]       s_data,
  input  logic                   s_last,
  output logic                   done,
  output logic [S_NUM*B_NUM-1:0] word,
  output logic [S_NUM-1:0]       keep
);
  localparam int unsigned W     = S_NUM * B_NUM;
  localparam int unsigned CNT_W = cnt_width(S_NUM);
`ifdef UTIL_SYM_PACK_MSB_FIRST_EN
  localparam order_e ORDER = ORDER_MSB_FIRST;
`else
  localparam order_e ORDER = ORDER_LSB_FIRST;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [S_NUM-1:0] keep_q, keep_d;
  int unsigned      slot;

  assign slot = slot_idx(32'(cnt_q), S_NUM, ORDER);
  assign done = accept & ((cnt_q == CNT_W'(S_NUM - 1)) | s_last);

  always_comb begin
    word   = acc_q;
    keep   = keep_q;
    acc_d  = acc_q;
    keep_d = keep_q;
    cnt_d  = cnt_q;
    if (accept) begin
      for (int unsigned i = 0; i < S_NUM; i++) begin
        if (i == slot) begin
          word[i*B_NUM +: B_NUM] = s_data;
          keep[i]                = 1'b1;
        end
      end
      // A closing beat hands the word to the output register and restarts at slot 0.
      if (done) begin
        acc_d  = '0;
        keep_d = '0;
        cnt_d  = '0;
      end else begin
        acc_d  = word;
        keep_d = keep;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      keep_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      keep_q <= keep_d;
    end
  end

endmodule

// File: rtl/util_sym_pack.sv
// Sequential symbol packer: B_NUM-bit symbols in, one S_NUM*B_NUM-bit word out with keep/last.
// Build option: UTIL_SYM_PACK_MSB_FIRST_EN selects MSB-first slot ordering (see util_sym_pack_acc).
module util_sym_pack
  import util_sym_pack_pkg::*;
#(
  parameter int unsigned S_NUM = 4,
  parameter int unsigned B_NUM = 8
) (
  input  logic            clk,
  input  logic            rst,
  util_sym_pack_if.slave  bus
);
  localparam int unsigned W = S_NUM * B_NUM;

  logic             accept;
  logic             done;
  logic [W-1:0]     word;
  logic [S_NUM-1:0] word_keep;

  logic             m_valid_q, m_valid_d;
  logic [W-1:0]     m_data_q,  m_data_d;
  logic [S_NUM-1:0] m_keep_q,  m_keep_d;
  logic             m_last_q,  m_last_d;

  assign bus.s_ready = !m_valid_q | bus.m_ready;
  assign accept      = bus.s_valid & bus.s_ready;

  util_sym_pack_acc #(
    .S_NUM (S_NUM),
    .B_NUM (B_NUM)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .s_data (bus.s_data),
    .s_last (bus.s_last),
    .done   (done),
    .word   (word),
    .keep   (word_keep)
  );

  // A closing accept can only happen when the register is empty or draining, so loading wins.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (done) begin
      m_valid_d = 1'b1;
      m_data_d  = word;
      m_keep_d  = word_keep;
      m_last_d  = bus.s_last;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_util_sym_pack.sv
// Bench for util_sym_pack (S_NUM=4, B_NUM=8): directed vector table, reset sequence, random scoreboard run.
module tb_util_sym_pack;
  localparam int unsigned S_NUM = 4;
  localparam int unsigned B_NUM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  util_sym_pack_if #(.S_NUM(S_NUM), .B_NUM(B_NUM)) bus ();

  util_sym_pack #(.S_NUM(S_NUM), .B_NUM(B_NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t          expq[$];
  logic [7:0]     symbuf[$];
  int             sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word built straight from the collected symbols: arrival k lands in slot k (or S_NUM-1-k).
  function automatic word_t build_word(input logic last);
    word_t w;
    int unsigned slot;
    w.data = '0;
    w.keep = '0;
    w.last = last;
    for (int k = 0; k < symbuf.size(); k++) begin
`ifdef UTIL_SYM_PACK_MSB_FIRST_EN
      slot = S_NUM - 1 - k;
`else
      slot = k;
`endif
      w.data = w.data | (32'(symbuf[k]) << (B_NUM * slot));
      w.keep = w.keep | (4'd1 << slot);
    end
    return w;
  endfunction

  // Called at the negedge: compares outputs with the model, then applies this cycle's transfers.
  task automatic model_cycle();
    logic  exp_sr;
    word_t w;
    exp_sr = (expq.size() == 0) || bus.m_ready;
    chk("m_valid", 32'(bus.m_valid), 32'(expq.size() != 0));
    chk("s_ready", 32'(bus.s_ready), 32'(exp_sr));
    if (rst) begin
      expq.delete();
      symbuf.delete();
    end else begin
      if (expq.size() != 0 && bus.m_ready) begin
        w = expq.pop_front();
        chk("m_data", bus.m_data, w.data);
        chk("m_keep", 32'(bus.m_keep), 32'(w.keep));
        chk("m_last", 32'(bus.m_last), 32'(w.last));
      end
      if (bus.s_valid && exp_sr) begin
        symbuf.push_back(bus.s_data);
        sent++;
        if (symbuf.size() == S_NUM || bus.s_last) begin
          expq.push_back(build_word(bus.s_last));
          symbuf.delete();
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic mr);
    @(posedge clk);
    #1;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.m_ready = mr;
    @(negedge clk);
    model_cycle();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        mr;
    logic        mv;
    logic        sr;
    logic        cd;
    logic [31:0] md;
    logic [3:0]  mk;
    logic        ml;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic v, logic [7:0] d, logic l, logic mr, logic mv, logic sr,
                               logic cd, logic [31:0] md, logic [3:0] mk, logic ml);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.mr = mr; r.mv = mv; r.sr = sr;
    r.cd = cd; r.md = md; r.mk = mk; r.ml = ml;
    return r;
  endfunction

  initial begin
    logic [31:0] w_full, w_ab, w_56, w_7, w_rst;
    logic [3:0]  k_ab, k_7;
`ifdef UTIL_SYM_PACK_MSB_FIRST_EN
    w_full = 32'h11223344; w_ab = 32'hAABB0000; k_ab = 4'hC;
    w_56   = 32'h55660000; w_7  = 32'h77000000; k_7  = 4'h8; w_rst = 32'h10203040;
`else
    w_full = 32'h44332211; w_ab = 32'h0000BBAA; k_ab = 4'h3;
    w_56   = 32'h00006655; w_7  = 32'h00000077; k_7  = 4'h1; w_rst = 32'h40302010;
`endif
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    rst = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_m_data", bus.m_data, 32'h0);
    chk("reset_m_keep", 32'(bus.m_keep), 32'h0);
    chk("reset_m_last", 32'(bus.m_last), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full word, 5-cycle backpressure, short word, simultaneous drain/load.
    tbl.push_back(mkv(1, 8'h11, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 8'h22, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 8'h33, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 8'h44, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (5) tbl.push_back(mkv(1, 8'h99, 0, 0, 1, 0, 1, w_full, 4'hF, 0));
    tbl.push_back(mkv(1, 8'hAA, 0, 1, 1, 1, 1, w_full, 4'hF, 0));
    tbl.push_back(mkv(1, 8'hBB, 1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 1, w_ab, k_ab, 1));
    tbl.push_back(mkv(1, 8'h55, 0, 1, 1, 1, 1, w_ab, k_ab, 1));
    tbl.push_back(mkv(1, 8'h66, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 8'h77, 1, 0, 1, 0, 1, w_56, k_ab, 1));
    tbl.push_back(mkv(1, 8'h77, 1, 1, 1, 1, 1, w_56, k_ab, 1));
    tbl.push_back(mkv(0, 8'h00, 0, 1, 1, 1, 1, w_7, k_7, 1));
    tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
      chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].sr));
      if (tbl[i].cd) begin
        chk($sformatf("vec%0d_m_data", i), bus.m_data, tbl[i].md);
        chk($sformatf("vec%0d_m_keep", i), 32'(bus.m_keep), 32'(tbl[i].mk));
        chk($sformatf("vec%0d_m_last", i), 32'(bus.m_last), 32'(tbl[i].ml));
      end
    end

    // Reset mid-word discards the partial word.
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'h30, 1'b0, 1'b1);
    chk("rst_no_early_word", 32'(bus.m_valid), 32'h0);
    step(1'b1, 8'h40, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'h1);
    chk("rst_m_data", bus.m_data, w_rst);
    chk("rst_m_keep", 32'(bus.m_keep), 32'hF);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic against the scoreboard.
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7);
    end
    chk("random_budget", 32'(sent >= 1000), 32'h1);
    step(1'b1, 8'($urandom), 1'b1, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_empty", 32'(expq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
